// File: rtl/fetch_align_buffer_if.sv
// Fetch/decode handshake bundle for fetch_align_buffer.
//   redirect / redirect_pc              : flush and restart the fetch stream
//   fw_valid / fw_ready / fw_addr / fw_data : fetched memory word (word-aligned)
//   inst_valid / inst_ready / inst / inst_pc / inst_compressed : aligned instruction
// Modports: slave = the align buffer, master = the fetch/decode side driving it.
interface fetch_align_buffer_if;
  localparam int unsigned XLEN = 32;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            fw_valid;
  logic            fw_ready;
  logic [XLEN-1:0] fw_addr;
  logic [XLEN-1:0] fw_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_compressed;

  modport master (
    output redirect, redirect_pc, fw_valid, fw_addr, fw_data, inst_ready,
    input  fw_ready, inst_valid, inst, inst_pc, inst_compressed
  );

  modport slave (
    input  redirect, redirect_pc, fw_valid, fw_addr, fw_data, inst_ready,
    output fw_ready, inst_valid, inst, inst_pc, inst_compressed
  );
endinterface

// File: rtl/fetch_align_buffer.sv
// Instruction fetch align buffer: turns a stream of word-aligned fetched
// memory words into aligned 16/32-bit instructions with their PCs.
// Storage is a 4-entry halfword FIFO kept as a packed shift register with the
// head (lowest PC) halfword in bits [15:0]; unused slots are always zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : redirect/redirect_pc, fw_* fetch word handshake,
//                 inst_* aligned instruction handshake (see fetch_align_buffer_if)
// Build option: define RVC_EN to enable compressed (16-bit) instruction support;
// without it every instruction is 32-bit and the PC steps by 4.
module fetch_align_buffer (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_align_buffer_if.slave  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned HW_W  = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned Q_W   = DEPTH * HW_W;

  // Architectural state
  logic [CNT_W-1:0] count;
  logic [Q_W-1:0]   q;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  exp_addr;
  logic             drop_low;

  // Combinational helpers
  logic             head_long_c;
  logic             avail_c;
  logic             inst_valid_c;
  logic             fw_ready_c;
  logic             fw_fire_c;
  logic             word_match_c;
  logic             enq_fire_c;
  logic             deq_fire_c;
  logic [1:0]       deq_n_c;
  logic [1:0]       enq_n_c;
  logic [CNT_W-1:0] rem_c;
  logic [CNT_W-1:0] count_n_c;
  logic [Q_W-1:0]   in_vec_c;
  logic [Q_W-1:0]   q_n_c;
  logic [XLEN-1:0]  redirect_pc_c;
  logic [XLEN-1:0]  redirect_word_c;
  logic             redirect_drop_c;
  logic             unused_redirect_bits;

  assign redirect_word_c = {bus.redirect_pc[XLEN-1:2], 2'b00};

`ifdef RVC_EN
  // Head halfword encoding decides the instruction length.
  assign head_long_c          = (q[1:0] == 2'b11);
  assign redirect_pc_c        = {bus.redirect_pc[XLEN-1:1], 1'b0};
  assign redirect_drop_c      = bus.redirect_pc[1];
  assign unused_redirect_bits = bus.redirect_pc[0];
`else
  // No compressed support: every instruction is a full word.
  assign head_long_c          = 1'b1;
  assign redirect_pc_c        = redirect_word_c;
  assign redirect_drop_c      = 1'b0;
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];
`endif

  // Handshake qualification; redirect blocks both sides in its cycle.
  assign avail_c      = head_long_c ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
  assign inst_valid_c = avail_c && !bus.redirect;
  assign fw_ready_c   = (count <= CNT_W'(2)) && !bus.redirect;
  assign fw_fire_c    = bus.fw_valid && fw_ready_c;
  assign word_match_c = (bus.fw_addr == exp_addr);
  assign enq_fire_c   = fw_fire_c && word_match_c;
  assign deq_fire_c   = inst_valid_c && bus.inst_ready;

  // Halfwords leaving and entering this cycle.
  assign deq_n_c = deq_fire_c ? (head_long_c ? 2'd2 : 2'd1) : 2'd0;
  assign enq_n_c = enq_fire_c ? (drop_low ? 2'd1 : 2'd2) : 2'd0;

  // A redirect into the upper half of a word skips the low halfword.
  assign in_vec_c = drop_low ? Q_W'(bus.fw_data[31:16]) : Q_W'(bus.fw_data);

  // Entries surviving the dequeue; new halfwords land right behind them.
  assign rem_c     = count - CNT_W'(deq_n_c);
  assign count_n_c = rem_c + CNT_W'(enq_n_c);

  // Next FIFO image: shift out consumed halfwords, then append the new ones.
  always_comb begin
    q_n_c = q >> {deq_n_c, 4'b0000};
    if (enq_fire_c) begin
      q_n_c = q_n_c | (in_vec_c << {rem_c, 4'b0000});
    end
  end

  // State update: redirect overrides every same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      q        <= '0;
      pc       <= '0;
      exp_addr <= '0;
      drop_low <= 1'b0;
    end else if (bus.redirect) begin
      count    <= '0;
      q        <= '0;
      pc       <= redirect_pc_c;
      exp_addr <= redirect_word_c;
      drop_low <= redirect_drop_c;
    end else begin
      count <= count_n_c;
      q     <= q_n_c;
      pc    <= pc + {29'b0, deq_n_c, 1'b0};
      if (enq_fire_c) begin
        exp_addr <= exp_addr + 32'd4;
        drop_low <= 1'b0;
      end
    end
  end

  // Outputs are driven straight from the FIFO head and the pc register.
  assign bus.fw_ready        = fw_ready_c;
  assign bus.inst_valid      = inst_valid_c;
  assign bus.inst            = inst_valid_c ? (head_long_c ? q[31:0] : {16'b0, q[15:0]}) : '0;
  assign bus.inst_compressed = inst_valid_c && !head_long_c;
  assign bus.inst_pc         = pc;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench for fetch_align_buffer: directed stimulus with a
// scoreboard queue of expected instructions popped as decode consumes them.
// Expectations follow the RVC_EN build option.
module tb_fetch_align_buffer;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  exp_t mon_e;

  fetch_align_buffer_if bus ();

  fetch_align_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic c);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    e.c    = c;
    sb.push_back(e);
  endtask

  // Decode-side monitor: every consumed instruction must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.inst_valid && bus.inst_ready) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_inst: observed inst %h pc %h expected none", bus.inst, bus.inst_pc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("inst", bus.inst, mon_e.inst);
        check("inst_pc", bus.inst_pc, mon_e.pc);
        check("inst_compressed", 32'(bus.inst_compressed), 32'(mon_e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.fw_ready) done = 1'b1;
      tick();
    end
    check("fw_accept", 32'(done), 32'd1);
    bus.fw_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d);
    bus.fw_valid = 1'b1;
    bus.fw_addr  = a;
    bus.fw_data  = d;
    wait_accept();
  endtask

  task automatic do_redirect(input logic [31:0] p);
    bus.redirect    = 1'b1;
    bus.redirect_pc = p;
    @(negedge clk);
    check("redirect_fw_ready", 32'(bus.fw_ready), 32'd0);
    check("redirect_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.redirect = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.fw_valid    = 1'b0;
    bus.fw_addr     = '0;
    bus.fw_data     = '0;
    bus.inst_ready  = 1'b0;

    // Reset values
    #2;
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_inst_c", 32'(bus.inst_compressed), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("post_rst_inst", bus.inst, 32'd0);
    check("post_rst_inst_pc", bus.inst_pc, 32'd0);
    check("post_rst_inst_c", 32'(bus.inst_compressed), 32'd0);
    check("post_rst_fw_ready", 32'(bus.fw_ready), 32'd1);

    // Two aligned 32-bit instructions, visible the cycle after acceptance
    bus.inst_ready = 1'b1;
    do_redirect(32'h100);
    push(32'h00A00093, 32'h100, 1'b0);
    push(32'h00100113, 32'h104, 1'b0);
    send_word(32'h100, 32'h00A00093);
    check("latency_valid", 32'(bus.inst_valid), 32'd1);
    send_word(32'h104, 32'h00100113);
    drain();

    // Compressed pair in one word
    do_redirect(32'h200);
`ifdef RVC_EN
    push(32'h00004501, 32'h200, 1'b1);
    push(32'h00004505, 32'h202, 1'b1);
`else
    push(32'h45054501, 32'h200, 1'b0);
`endif
    send_word(32'h200, 32'h45054501);
    drain();

    // 32-bit instruction straddling a word boundary
    do_redirect(32'h302);
`ifdef RVC_EN
    push(32'h00A00093, 32'h302, 1'b0);
    push(32'h00000000, 32'h306, 1'b1);
    send_word(32'h300, 32'h00931234);
    check("straddle_hold", 32'(bus.inst_valid), 32'd0);
    tick();
    check("straddle_hold2", 32'(bus.inst_valid), 32'd0);
`else
    push(32'h00931234, 32'h300, 1'b0);
    push(32'h000000A0, 32'h304, 1'b0);
    send_word(32'h300, 32'h00931234);
    check("word_latency", 32'(bus.inst_valid), 32'd1);
`endif
    send_word(32'h304, 32'h000000A0);
    drain();

    // Backpressure: FIFO fills after two words, third waits, nothing lost
    bus.inst_ready = 1'b0;
    do_redirect(32'h600);
    push(32'h01000013, 32'h600, 1'b0);
    push(32'h02000013, 32'h604, 1'b0);
    push(32'h03000013, 32'h608, 1'b0);
    send_word(32'h600, 32'h01000013);
    send_word(32'h604, 32'h02000013);
    bus.fw_valid = 1'b1;
    bus.fw_addr  = 32'h608;
    bus.fw_data  = 32'h03000013;
    repeat (3) begin
      @(negedge clk);
      check("full_fw_ready", 32'(bus.fw_ready), 32'd0);
      check("full_inst_valid", 32'(bus.inst_valid), 32'd1);
      tick();
    end
    bus.inst_ready = 1'b1;
    wait_accept();
    drain();

    // Stale word held across the redirect, then accepted and discarded
    bus.fw_valid = 1'b1;
    bus.fw_addr  = 32'h400;
    bus.fw_data  = 32'hDEAD0013;
    do_redirect(32'h500);
    wait_accept();
    check("stale_no_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("stale_no_valid2", 32'(bus.inst_valid), 32'd0);
    push(32'h05000013, 32'h500, 1'b0);
    send_word(32'h500, 32'h05000013);
    drain();

    // PC and expected address wrap
    do_redirect(32'hFFFFFFFC);
    push(32'h0A000013, 32'hFFFFFFFC, 1'b0);
    push(32'h0B000013, 32'h00000000, 1'b0);
    send_word(32'hFFFFFFFC, 32'h0A000013);
    send_word(32'h00000000, 32'h0B000013);
    drain();

    // Reset mid-operation with buffered halfwords
    bus.inst_ready = 1'b0;
    do_redirect(32'h702);
    send_word(32'h700, 32'h00130013);
    send_word(32'h704, 32'h00130013);
    check("pre_rst_valid", 32'(bus.inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("mid_rst_inst", bus.inst, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.inst_ready = 1'b1;
    check("mid_rst_fw_ready", 32'(bus.fw_ready), 32'd1);
    check("mid_rst_inst_pc", bus.inst_pc, 32'd0);
    do_redirect(32'h0);
    repeat (4) tick();
    check("no_stale_inst", 32'(bus.inst_valid), 32'd0);
    push(32'h00000013, 32'h0, 1'b0);
    send_word(32'h0, 32'h00000013);
    drain();

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
